// File: rtl/ofmap_bit_packer.sv
// ofmap_bit_packer
// Packs the 1-bit binarized ofmap result stream into WORD_WIDTH-bit masked
// word writes for the ofmap BRAM. When the layer ends, it flushes any partial
// word and then pulses o_done for one cycle.
// Optional build macro: OFMAP_PACK_STATS_EN adds the o_ones_cnt and
// o_word_cnt statistics outputs.
module ofmap_bit_packer #(
   parameter int OFMAPS_BRAM_ADDR_WIDTH = 12,
   parameter int BIT_IDX_WIDTH          = 5
) (
   input  logic                                              clk,
   input  logic                                              rst_n,
   input  logic                                              i_data,
   input  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0]                 i_addr,
   input  logic                                              i_valid,
   input  logic                                              i_last,
   output logic                                              bram_we,
   output logic [OFMAPS_BRAM_ADDR_WIDTH-BIT_IDX_WIDTH-1:0]   bram_addr,
   output logic [(2**BIT_IDX_WIDTH)-1:0]                     bram_wdata,
   output logic [(2**BIT_IDX_WIDTH)-1:0]                     bram_wmask,
`ifdef OFMAP_PACK_STATS_EN
   output logic [15:0]                                       o_ones_cnt,
   output logic [15:0]                                       o_word_cnt,
`endif
   output logic                                              o_done,
   output logic                                              o_busy
);

   localparam int WORD_WIDTH      = 2**BIT_IDX_WIDTH;
   localparam int WORD_ADDR_WIDTH = OFMAPS_BRAM_ADDR_WIDTH - BIT_IDX_WIDTH;

   typedef enum logic [1:0] {S_EMPTY, S_FILL, S_DRAIN, S_DONE} state_t;

   state_t                       state_reg, state_next;
   logic [WORD_WIDTH-1:0]        data_reg, data_next;
   logic [WORD_WIDTH-1:0]        mask_reg, mask_next;
   logic [WORD_ADDR_WIDTH-1:0]   waddr_reg, waddr_next;

   logic                         we_next;
   logic [WORD_ADDR_WIDTH-1:0]   wr_addr_next;
   logic [WORD_WIDTH-1:0]        wr_data_next;
   logic [WORD_WIDTH-1:0]        wr_mask_next;

   logic [WORD_ADDR_WIDTH-1:0]   in_waddr;
   logic [BIT_IDX_WIDTH-1:0]     in_idx;
   logic [WORD_WIDTH-1:0]        onehot;
   logic [WORD_WIDTH-1:0]        bit_val;
   logic [WORD_WIDTH-1:0]        merged_data;
   logic [WORD_WIDTH-1:0]        merged_mask;
   logic                         hit;

   assign in_waddr    = i_addr[OFMAPS_BRAM_ADDR_WIDTH-1:BIT_IDX_WIDTH];
   assign in_idx      = i_addr[BIT_IDX_WIDTH-1:0];
   assign onehot      = WORD_WIDTH'(1) << in_idx;
   assign bit_val     = i_data ? onehot : '0;
   // The buffer is always cleared in S_EMPTY, so merging into it there
   // yields a fresh one-bit word.
   assign merged_data = (data_reg & ~onehot) | bit_val;
   assign merged_mask = mask_reg | onehot;
   assign hit         = (state_reg == S_EMPTY) || (waddr_reg == in_waddr);

   // Next-state, buffer update and write decision
   always_comb begin
      state_next   = state_reg;
      data_next    = data_reg;
      mask_next    = mask_reg;
      waddr_next   = waddr_reg;
      we_next      = 1'b0;
      wr_addr_next = waddr_reg;
      wr_data_next = data_reg;
      wr_mask_next = mask_reg;
      unique case (state_reg)
         S_EMPTY, S_FILL: begin
            if (i_valid && hit) begin
               if ((&merged_mask) || i_last) begin
                  // Word complete or layer ending: write the merged word now
                  we_next      = 1'b1;
                  wr_addr_next = in_waddr;
                  wr_data_next = merged_data;
                  wr_mask_next = merged_mask;
                  data_next    = '0;
                  mask_next    = '0;
                  waddr_next   = '0;
                  state_next   = i_last ? S_DONE : S_EMPTY;
               end else begin
                  data_next  = merged_data;
                  mask_next  = merged_mask;
                  waddr_next = in_waddr;
                  state_next = S_FILL;
               end
            end else if (i_valid) begin
               // New word address: write the old buffer, start the new one
               we_next    = 1'b1;
               data_next  = bit_val;
               mask_next  = onehot;
               waddr_next = in_waddr;
               state_next = i_last ? S_DRAIN : S_FILL;
            end else if (i_last) begin
               we_next    = (state_reg == S_FILL);
               data_next  = '0;
               mask_next  = '0;
               waddr_next = '0;
               state_next = S_DONE;
            end
         end
         S_DRAIN: begin
            we_next    = 1'b1;
            data_next  = '0;
            mask_next  = '0;
            waddr_next = '0;
            state_next = S_DONE;
         end
         S_DONE: begin
            state_next = S_EMPTY;
         end
         default: begin
            state_next = S_EMPTY;
         end
      endcase
   end

   // State and buffer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_EMPTY;
         data_reg  <= '0;
         mask_reg  <= '0;
         waddr_reg <= '0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
         mask_reg  <= mask_next;
         waddr_reg <= waddr_next;
      end
   end

   // Registered outputs; the write bus holds its last value between strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bram_we    <= 1'b0;
         bram_addr  <= '0;
         bram_wdata <= '0;
         bram_wmask <= '0;
         o_done     <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         bram_we <= we_next;
         if (we_next) begin
            bram_addr  <= wr_addr_next;
            bram_wdata <= wr_data_next;
            bram_wmask <= wr_mask_next;
         end
         o_done <= (state_reg == S_DONE);
         o_busy <= (state_next != S_EMPTY) || (|mask_next);
      end
   end

`ifdef OFMAP_PACK_STATS_EN
   logic [15:0] ones_cnt_reg;
   logic [15:0] word_cnt_reg;
   logic        clr_pending_reg;
   logic        accept;

   assign accept     = i_valid && ((state_reg == S_EMPTY) || (state_reg == S_FILL));
   assign o_ones_cnt = ones_cnt_reg;
   assign o_word_cnt = word_cnt_reg;

   // Saturating statistics, restarted by the first accepted beat after o_done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_cnt_reg    <= '0;
         word_cnt_reg    <= '0;
         clr_pending_reg <= 1'b0;
      end else begin
         if (state_reg == S_DONE) begin
            clr_pending_reg <= 1'b1;
         end else if (accept) begin
            clr_pending_reg <= 1'b0;
         end
         if (accept && clr_pending_reg) begin
            ones_cnt_reg <= {15'b0, i_data};
            word_cnt_reg <= {15'b0, we_next};
         end else begin
            if (accept && i_data && (ones_cnt_reg != 16'hFFFF)) begin
               ones_cnt_reg <= ones_cnt_reg + 16'd1;
            end
            if (we_next && (word_cnt_reg != 16'hFFFF)) begin
               word_cnt_reg <= word_cnt_reg + 16'd1;
            end
         end
      end
   end
`endif

`ifndef SYNTHESIS
   // A beat arriving while draining or signalling done is dropped
   no_beat_after_last: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_valid && ((state_reg == S_DRAIN) || (state_reg == S_DONE))));
`endif

endmodule
